// File: rtl/mac_layer_seq_pkg.sv
// Shared types and constants for the fully-connected layer sequencer:
// FSM state encoding, MAC phase codes and datapath widths.
package mac_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        ACT  = 2'b10,
        HOLD = 2'b11
    } state_e;

    // Phase codes driven onto the MAC's 2-bit counter input.
    localparam logic [1:0] PH_ADDR = 2'b00;
    localparam logic [1:0] PH_MUL  = 2'b01;
    localparam logic [1:0] PH_SUM  = 2'b10;
    localparam logic [1:0] PH_ACC  = 2'b11;

    // Sign-magnitude chunk sum / accumulator width and result width.
    localparam int SM_W  = 21;
    localparam int RES_W = 8;

endpackage

// File: rtl/mac_layer_seq_if.sv
// Control, memory/MAC and result-handshake signals of mac_layer_seq.
// master: the sequencer side; slave: the surrounding memories, MAC and consumer.
interface mac_layer_seq_if #(
    parameter int NUM_CHUNKS  = 8,
    parameter int NUM_NEURONS = 10
);
    import mac_seq_pkg::*;

    localparam int CH_W = $clog2(NUM_CHUNKS);
    localparam int NR_W = $clog2(NUM_NEURONS);
    localparam int WA_W = $clog2(NUM_NEURONS * NUM_CHUNKS);

    logic              start;
    logic              busy;
    logic              done;
    logic [CH_W-1:0]   in_addr;
    logic [WA_W-1:0]   w_addr;
    logic [1:0]        mac_phase;
    logic [SM_W-1:0]   mac_out;
    logic              res_valid;
    logic              res_ready;
    logic [RES_W-1:0]  res_data;
    logic [NR_W-1:0]   res_idx;

    modport master (
        input  start, mac_out, res_ready,
        output busy, done, in_addr, w_addr, mac_phase, res_valid, res_data, res_idx
    );

    modport slave (
        output start, mac_out, res_ready,
        input  busy, done, in_addr, w_addr, mac_phase, res_valid, res_data, res_idx
    );

endinterface

// File: rtl/mac_layer_seq_sm_add_sat.sv
// Combinational sign-magnitude adder: same signs add with saturation at the
// maximum magnitude, opposite signs subtract with the larger operand's sign.
// A zero magnitude result always carries sign 0.
module sm_add_sat
    import mac_seq_pkg::*;
(
    input  logic [SM_W-1:0] a,
    input  logic [SM_W-1:0] b,
    output logic [SM_W-1:0] y
);
    localparam int MAG_W = SM_W - 1;

    logic             sign_a;
    logic             sign_b;
    logic             sign_y;
    logic [MAG_W-1:0] mag_a;
    logic [MAG_W-1:0] mag_b;
    logic [MAG_W-1:0] mag_y;
    logic [MAG_W:0]   mag_sum;

    assign sign_a = a[SM_W-1];
    assign sign_b = b[SM_W-1];
    assign mag_a  = a[MAG_W-1:0];
    assign mag_b  = b[MAG_W-1:0];

    // Select add or subtract by sign agreement, then normalise -0 to +0.
    always_comb begin
        mag_sum = {1'b0, mag_a} + {1'b0, mag_b};
        sign_y  = sign_a;
        mag_y   = '0;
        if (sign_a == sign_b) begin
            mag_y = mag_sum[MAG_W] ? '1 : mag_sum[MAG_W-1:0];
        end else if (mag_a >= mag_b) begin
            mag_y = mag_a - mag_b;
        end else begin
            mag_y  = mag_b - mag_a;
            sign_y = sign_b;
        end
        if (mag_y == '0) begin
            sign_y = 1'b0;
        end
    end

    assign y = {sign_y, mag_y};

endmodule

// File: rtl/mac_layer_seq.sv
// Fully-connected layer sequencer around an 8-lane sign-magnitude MAC.
// Walks input/weight memories chunk by chunk, drives the MAC phase counter,
// accumulates chunk sums in sign-magnitude and emits one quantised 8-bit
// result per neuron over valid/ready.
// Build option: define MAC_LAYER_SEQ_RELU_EN to clamp negative results to 0x00.
module mac_layer_seq
    import mac_seq_pkg::*;
#(
    parameter int NUM_CHUNKS  = 8,
    parameter int NUM_NEURONS = 10,
    parameter int OUT_SHIFT   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mac_layer_seq_if.master       bus
);
    localparam int CH_W  = $clog2(NUM_CHUNKS);
    localparam int NR_W  = $clog2(NUM_NEURONS);
    localparam int WA_W  = $clog2(NUM_NEURONS * NUM_CHUNKS);
    localparam int MAG_W = SM_W - 1;

    localparam logic [CH_W-1:0]  LAST_CHUNK  = CH_W'(NUM_CHUNKS - 1);
    localparam logic [NR_W-1:0]  LAST_NEURON = NR_W'(NUM_NEURONS - 1);
    localparam logic [MAG_W-1:0] RES_MAX     = MAG_W'(2 ** (RES_W - 1) - 1);

    state_e            state_q;
    state_e            state_d;
    logic [CH_W-1:0]   chunk_q;
    logic [NR_W-1:0]   neuron_q;
    logic [1:0]        phase_q;
    logic [SM_W-1:0]   acc_q;
    logic [SM_W-1:0]   acc_sum;
    logic              res_valid_q;
    logic [RES_W-1:0]  res_data_q;
    logic [NR_W-1:0]   res_idx_q;
    logic              done_q;
    logic              last_chunk;
    logic              last_neuron;
    logic              handshake;

    // Shift the magnitude down, clamp to 7 bits, drop -0 and optionally rectify.
    function automatic logic [RES_W-1:0] quantize(input logic [SM_W-1:0] acc);
        logic [MAG_W-1:0] shifted;
        logic [RES_W-2:0] mag;
        logic             sgn;
        shifted = acc[MAG_W-1:0] >> OUT_SHIFT;
        if (shifted > RES_MAX) begin
            mag = '1;
        end else begin
            mag = shifted[RES_W-2:0];
        end
        sgn = acc[SM_W-1] && (mag != '0);
`ifdef MAC_LAYER_SEQ_RELU_EN
        if (sgn) begin
            sgn = 1'b0;
            mag = '0;
        end
`endif
        return {sgn, mag};
    endfunction

    sm_add_sat u_add (
        .a (acc_q),
        .b (bus.mac_out),
        .y (acc_sum)
    );

    assign last_chunk  = (chunk_q == LAST_CHUNK);
    assign last_neuron = (neuron_q == LAST_NEURON);
    assign handshake   = res_valid_q && bus.res_ready;

    // Addresses come straight from the registered counters, stable across all four phases.
    assign bus.in_addr   = chunk_q;
    assign bus.w_addr    = WA_W'(32'(neuron_q) * 32'(NUM_CHUNKS) + 32'(chunk_q));
    assign bus.mac_phase = phase_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_idx   = res_idx_q;

    // Next-state selection for the IDLE/RUN/ACT/HOLD sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (phase_q == PH_ACC && last_chunk) state_d = ACT;
            ACT:     state_d = HOLD;
            HOLD:    if (handshake) state_d = last_neuron ? IDLE : RUN;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, accumulator and result registers, advanced per state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chunk_q     <= '0;
            neuron_q    <= '0;
            phase_q     <= PH_ADDR;
            acc_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        chunk_q  <= '0;
                        neuron_q <= '0;
                        acc_q    <= '0;
                        phase_q  <= PH_ADDR;
                    end
                end
                RUN: begin
                    phase_q <= phase_q + 2'd1;
                    if (phase_q == PH_ACC) begin
                        acc_q <= acc_sum;
                        if (!last_chunk) begin
                            chunk_q <= chunk_q + CH_W'(1);
                        end
                    end
                end
                ACT: begin
                    res_data_q  <= quantize(acc_q);
                    res_idx_q   <= neuron_q;
                    res_valid_q <= 1'b1;
                end
                HOLD: begin
                    if (handshake) begin
                        res_valid_q <= 1'b0;
                        chunk_q     <= '0;
                        acc_q       <= '0;
                        phase_q     <= PH_ADDR;
                        if (last_neuron) begin
                            neuron_q <= '0;
                            done_q   <= 1'b1;
                        end else begin
                            neuron_q <= neuron_q + NR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_layer_seq.sv
// Scoreboard bench for mac_layer_seq: two instances (OUT_SHIFT 0 and 10) share
// one stimulus stream; each has its own memory + MAC behavioural model.
module tb_mac_layer_seq;
    import mac_seq_pkg::*;

    localparam int NC     = 8;
    localparam int NN     = 10;
    localparam int SHIFT0 = 0;
    localparam int SHIFT1 = 10;

    logic clk;
    logic rst_n;
    logic start;
    logic res_ready;

    int ready_mode = 0;
    int n_cmp      = 0;
    int n_bad      = 0;
    int done_cnt   = 0;
    int exp_done   = 0;
    int wait_cnt   = 0;

    logic [7:0] in_mem [NC][8];
    logic [7:0] w_mem  [NN*NC][8];

    int exp_q0 [$];
    int exp_q1 [$];

    logic       held_v [2];
    logic [7:0] held_d [2];
    logic [3:0] held_i [2];

    int rd_ia0 = 0, rd_wa0 = 0, cap_ia0 = 0, cap_wa0 = 0;
    int rd_ia1 = 0, rd_wa1 = 0, cap_ia1 = 0, cap_wa1 = 0;
    logic [20:0] mac0 = '0;
    logic [20:0] mac1 = '0;

    mac_layer_seq_if #(.NUM_CHUNKS(NC), .NUM_NEURONS(NN)) bus0 ();
    mac_layer_seq_if #(.NUM_CHUNKS(NC), .NUM_NEURONS(NN)) bus1 ();

    assign bus0.start     = start;
    assign bus1.start     = start;
    assign bus0.res_ready = res_ready;
    assign bus1.res_ready = res_ready;
    assign bus0.mac_out   = mac0;
    assign bus1.mac_out   = mac1;

    mac_layer_seq #(.NUM_CHUNKS(NC), .NUM_NEURONS(NN), .OUT_SHIFT(SHIFT0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    mac_layer_seq #(.NUM_CHUNKS(NC), .NUM_NEURONS(NN), .OUT_SHIFT(SHIFT1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference arithmetic ----------------
    function automatic int lane(input logic [7:0] b);
        int m;
        m = int'(b[6:0]);
        return b[7] ? -m : m;
    endfunction

    function automatic int chunk_val(input int ia, input int wa);
        int s = 0;
        for (int l = 0; l < 8; l++) s += lane(in_mem[ia][l]) * lane(w_mem[wa][l]);
        return s;
    endfunction

    function automatic logic [20:0] to_sm(input int v);
        int m;
        m = (v < 0) ? -v : v;
        return {(v < 0), 20'(m)};
    endfunction

    // Expected result byte of neuron n for a given output shift.
    function automatic logic [7:0] expect_res(input int n, input int shift);
        int am, m, v;
        bit as, s;
        am = 0;
        as = 1'b0;
        for (int c = 0; c < NC; c++) begin
            v = chunk_val(c, n * NC + c);
            s = (v < 0);
            m = s ? -v : v;
            if (as == s) begin
                am = am + m;
                if (am > 1048575) am = 1048575;
            end else if (am >= m) begin
                am = am - m;
            end else begin
                am = m - am;
                as = s;
            end
            if (am == 0) as = 1'b0;
        end
        m = am >> shift;
        if (m > 127) m = 127;
        s = as && (m != 0);
`ifdef MAC_LAYER_SEQ_RELU_EN
        if (s) return 8'h00;
`endif
        return {s, 7'(m)};
    endfunction

    // ---------------- memory + MAC models ----------------
    always @(posedge clk) begin
        rd_ia0 <= int'(bus0.in_addr);
        rd_wa0 <= int'(bus0.w_addr);
        if (bus0.mac_phase == PH_MUL) begin
            cap_ia0 <= rd_ia0;
            cap_wa0 <= rd_wa0;
        end
        if (bus0.mac_phase == PH_SUM) mac0 <= to_sm(chunk_val(cap_ia0, cap_wa0));
    end

    always @(posedge clk) begin
        rd_ia1 <= int'(bus1.in_addr);
        rd_wa1 <= int'(bus1.w_addr);
        if (bus1.mac_phase == PH_MUL) begin
            cap_ia1 <= rd_ia1;
            cap_wa1 <= rd_wa1;
        end
        if (bus1.mac_phase == PH_SUM) mac1 <= to_sm(chunk_val(cap_ia1, cap_wa1));
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic v, input logic r,
                       input logic [7:0] d, input logic [3:0] ix);
        int e;
        int qs;
        if (!v) begin
            held_v[k] = 1'b0;
        end else begin
            if (held_v[k]) begin
                check(k == 0 ? "hold_data0" : "hold_data1", 32'(d), 32'(held_d[k]));
                check(k == 0 ? "hold_idx0" : "hold_idx1", 32'(ix), 32'(held_i[k]));
            end
            held_v[k] = 1'b1;
            held_d[k] = d;
            held_i[k] = ix;
            if (r) begin
                held_v[k] = 1'b0;
                qs = (k == 0) ? exp_q0.size() : exp_q1.size();
                check(k == 0 ? "result_expected0" : "result_expected1", 32'(qs != 0), 1);
                if (qs != 0) begin
                    e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check(k == 0 ? "res_data0" : "res_data1", 32'(d), 32'(e[7:0]));
                    check(k == 0 ? "res_idx0" : "res_idx1", 32'(ix), 32'(e[11:8]));
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_v[0] = 1'b0;
                held_v[1] = 1'b0;
            end else begin
                mon(0, bus0.res_valid, res_ready, bus0.res_data, bus0.res_idx);
                mon(1, bus1.res_valid, res_ready, bus1.res_data, bus1.res_idx);
                if (bus0.done) done_cnt++;
            end
        end
    end

    // Ready policy: 0 always ready, 1 stall 5 cycles per result, 2 random.
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: res_ready = 1'b1;
                1: begin
                    if (bus0.res_valid && !res_ready) begin
                        if (wait_cnt >= 5) res_ready = 1'b1;
                        else wait_cnt++;
                    end else begin
                        res_ready = 1'b0;
                        wait_cnt  = 0;
                    end
                end
                default: res_ready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic fill_const(input logic [7:0] ib, input logic [7:0] wb);
        for (int c = 0; c < NC; c++) for (int l = 0; l < 8; l++) in_mem[c][l] = ib;
        for (int a = 0; a < NN * NC; a++) for (int l = 0; l < 8; l++) w_mem[a][l] = wb;
    endtask

    task automatic fill_cancel();
        for (int c = 0; c < NC; c++) for (int l = 0; l < 8; l++) in_mem[c][l] = 8'h05;
        for (int a = 0; a < NN * NC; a++)
            for (int l = 0; l < 8; l++) w_mem[a][l] = ((a % NC) % 2 == 1) ? 8'h83 : 8'h03;
    endtask

    task automatic fill_rand(input int maxmag);
        for (int c = 0; c < NC; c++)
            for (int l = 0; l < 8; l++)
                in_mem[c][l] = {1'($urandom_range(0, 1)), 7'($urandom_range(0, maxmag))};
        for (int a = 0; a < NN * NC; a++)
            for (int l = 0; l < 8; l++)
                w_mem[a][l] = {1'($urandom_range(0, 1)), 7'($urandom_range(0, maxmag))};
    endtask

    task automatic push_expect();
        for (int n = 0; n < NN; n++) begin
            exp_q0.push_back((n << 8) | int'(expect_res(n, SHIFT0)));
            exp_q1.push_back((n << 8) | int'(expect_res(n, SHIFT1)));
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (bus0.done) got = 1'b1;
        end
        check("done_seen", 32'(got), 1);
        if (got) begin
            check("busy_with_done", 32'(bus0.busy), 0);
            check("done_dut1", 32'(bus1.done), 1);
        end
    endtask

    task automatic run_layer(input int mode, input bit extra);
        int cyc;
        bit got;
        ready_mode = mode;
        push_expect();
        pulse_start();
        cyc = 0;
        got = 1'b0;
        while (cyc < 200 && !got) begin
            @(negedge clk);
            cyc++;
            if (bus0.res_valid) got = 1'b1;
        end
        check("first_valid_cycle", 32'(cyc), 32'(4 * NC + 2));
        check("first_valid_dut1", 32'(bus1.res_valid), 1);
        fork
            begin
                if (extra) begin
                    for (int i = 0; i < 3; i++) begin
                        repeat (41) @(posedge clk);
                        #1;
                        if (bus0.busy) start = 1'b1;
                        @(posedge clk);
                        #1 start = 1'b0;
                    end
                end
            end
            wait_done();
        join
        exp_done++;
        repeat (8) @(negedge clk);
        check("done_count", 32'(done_cnt), 32'(exp_done));
        check("queue0_drained", 32'(exp_q0.size()), 0);
        check("queue1_drained", 32'(exp_q1.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(bus0.busy), 0);
        check({tag, "_done"}, 32'(bus0.done), 0);
        check({tag, "_res_valid"}, 32'(bus0.res_valid), 0);
        check({tag, "_res_data"}, 32'(bus0.res_data), 0);
        check({tag, "_res_idx"}, 32'(bus0.res_idx), 0);
        check({tag, "_mac_phase"}, 32'(bus0.mac_phase), 0);
        check({tag, "_in_addr"}, 32'(bus0.in_addr), 0);
        check({tag, "_w_addr"}, 32'(bus0.w_addr), 0);
        check({tag, "_busy1"}, 32'(bus1.busy), 0);
        check({tag, "_res_valid1"}, 32'(bus1.res_valid), 0);
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_init");
        rst_n = 1'b1;

        fill_const(8'h01, 8'h01); run_layer(0, 1'b0);
        fill_const(8'h01, 8'h81); run_layer(1, 1'b0);
        fill_const(8'h7F, 8'h7F); run_layer(2, 1'b0);
        fill_cancel();            run_layer(0, 1'b0);
        fill_rand(3);             run_layer(1, 1'b1);
        fill_rand(127);           run_layer(2, 1'b1);
        fill_rand(20);            run_layer(1, 1'b0);

        // Abort a run in the middle of neuron 1.
        fill_rand(127);
        ready_mode = 0;
        push_expect();
        pulse_start();
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        exp_q0.delete();
        exp_q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check("done_after_abort", 32'(done_cnt), 32'(exp_done));
        check("valid_after_abort", 32'(bus0.res_valid), 0);

        fill_rand(5); run_layer(0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_layer_seq.md
# mac_layer_seq

Sequencer for one fully-connected layer built around the 8-lane sign-magnitude MAC. Per neuron it walks the input and weight memories in 8-lane chunks and drives the MAC's 2-bit phase counter. It accumulates each 21-bit chunk sum in sign-magnitude, then quantizes and optionally rectifies the result. One 8-bit result per neuron is emitted over a valid/ready handshake.

## Interface
- NUM_CHUNKS, 8: 8-lane chunks per neuron (64 inputs); the accumulator cannot overflow for values up to 8.
- NUM_NEURONS, 10: neurons per layer run.
- OUT_SHIFT, 10: right shift applied to the accumulator magnitude before output saturation.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to run the layer; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result handshake.
- in_addr  out  $clog2(NUM_CHUNKS)  input-memory chunk address, equal to the current chunk.
- w_addr  out  $clog2(NUM_NEURONS*NUM_CHUNKS)  weight address, equal to neuron*NUM_CHUNKS + chunk.
- mac_phase  out  2  phase drive to the MAC's counter_4 input.
- mac_out  in  21  MAC chunk sum: bit 20 is the sign, bits 19:0 are the magnitude.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  8  result: bit 7 is the sign, bits 6:0 are the magnitude.
- res_idx  out  $clog2(NUM_NEURONS)  index of the neuron that produced res_data.

## Operation
- States: IDLE, RUN, ACT, HOLD.
- IDLE: start=1 → RUN. On entry, chunk=0, neuron=0, acc=+0, phase=00.
- RUN: mac_phase advances by 1 each cycle, 00→01→10→11→00.
  - Addresses are decoded from the registered counters, so they are stable for all 4 phases.
  - Memories have synchronous 1-cycle read latency, so data is valid in phase 01.
  - The MAC captures products at the end of phase 01 and registers its sum at the end of phase 10.
  - In phase 11: acc ← sm_add(acc, mac_out). If chunk == NUM_CHUNKS-1, go to ACT; otherwise chunk++.
- ACT (1 cycle): compute mag = min(acc_mag >> OUT_SHIFT, 127).
  - Register res_data = {acc_sign, mag[6:0]} and res_idx = neuron.
  - Set res_valid=1, then go to HOLD.
- HOLD: res_valid, res_data and res_idx stay constant until res_valid && res_ready.
  - On that handshake, if neuron == NUM_NEURONS-1: res_valid=0, done=1 for one cycle, go to IDLE.
  - Otherwise: neuron++, chunk=0, acc=+0, res_valid=0, go to RUN.
- Sign-magnitude add:
  - Equal signs: add magnitudes, saturating at 2^20-1.
  - Different signs: the larger magnitude wins, with its sign.
  - Any zero magnitude is normalized to sign 0 (no -0 anywhere, including res_data).
- mac_phase is 00 in IDLE, ACT and HOLD. The MAC's output does not change outside RUN.
- start while busy is ignored. res_ready outside HOLD is ignored.

## Timing
- Reset (asynchronous, immediate): state=IDLE, counters=0, acc=0.
  - Outputs: busy=0, done=0, res_valid=0, res_data=0, res_idx=0, mac_phase=00, in_addr=0, w_addr=0.
- Reset asserted mid-RUN or mid-HOLD aborts the run. No result or done is produced for it.
- Take start sampled at edge 0:
  - RUN occupies cycles 1…4·NUM_CHUNKS.
  - ACT is cycle 4·NUM_CHUNKS+1.
  - res_valid is first high in cycle 4·NUM_CHUNKS+2 (34 with defaults).
- With res_ready held high, the per-neuron period is 4·NUM_CHUNKS+2 cycles.
- done is high in the cycle after the final handshake. busy falls in that same cycle.
- A new start is accepted in the cycle done is high, since the state is already IDLE.

## Configuration
- MAC_LAYER_SEQ_RELU_EN defined: in ACT, a negative accumulator produces res_data=0x00.
- MAC_LAYER_SEQ_RELU_EN undefined: the sign is preserved; res_data = {acc_sign, mag}.

## Structure
- Package mac_seq_pkg holds:
  - the state enum (IDLE, RUN, ACT, HOLD);
  - the MAC phase constants (PH_ADDR=00, PH_MUL=01, PH_SUM=10, PH_ACC=11);
  - the SM_W=21 and RES_W=8 widths.
- One sub-module, sm_add_sat: a 21-bit combinational sign-magnitude adder with saturation and -0 normalization.

## Test plan
- Reset: assert rst_n=0 mid-RUN → all outputs read 0 in the same cycle, mac_phase=00, and no done follows.
- One-neuron run, OUT_SHIFT=0, all inputs 0x01 and weights 0x01 → each mac_out=+8, acc=+64, res_data=0x40, res_idx=0, res_valid in cycle 34.
- Weights 0x81 (-1), inputs 0x01, OUT_SHIFT=0 → acc=-64. Expect res_data=0x00 with MAC_LAYER_SEQ_RELU_EN and 0xC0 without.
- Saturation: inputs and weights all 0x7F, 8 chunks, OUT_SHIFT=10 → acc_mag=1032256, shifted value 1008, clamped res_data=0x7F.
- Cancellation: chunks alternate +X and -X → acc is +0 and res_data=0x00 (never 0x80).
- Full layer of 10 neurons with res_ready low for 5 cycles in each HOLD:
  - res_valid, res_data and res_idx stay stable while res_ready is low;
  - res_idx runs 0…9;
  - done pulses once;
  - start pulses during busy are ignored.
